// File: rtl/channel_arbiter.sv
// channel_arbiter: N-to-1 round-robin merger feeding a 2-entry output buffer.
// Each granted message is tagged with its source index. The downstream
// full flag only gates out_valid and never reaches the grant logic.
module channel_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 initialize,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_is_taken,
    output logic [WIDTH-1:0]     out_data,
    output logic [SRC_W-1:0]     out_source,
    output logic                 out_valid,
    input  logic                 out_is_full,
    output logic [CNT_W-1:0]     forwarded_count
);

    localparam int ENTRY_W = WIDTH + SRC_W;
    localparam logic [SRC_W:0]   N_EXT    = (SRC_W + 1)'(N);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N - 1);
    localparam logic [N-1:0]     ONE_N    = {{(N - 1){1'b0}}, 1'b1};

    logic                 clear;
    logic [WIDTH-1:0]     in_words [N];
    logic [ENTRY_W-1:0]   head_reg;
    logic [ENTRY_W-1:0]   tail_reg;
    logic [1:0]           occ_reg;
    logic [1:0]           occ_next;
    logic [SRC_W-1:0]     rr_ptr_reg;
    logic [SRC_W-1:0]     rr_ptr_next;
    logic [CNT_W-1:0]     count_reg;
    logic [2*N-1:0]       valid_twice;
    logic [N-1:0]         valid_rotated;
    logic                 grant_found;
    logic [SRC_W-1:0]     grant_offset;
    logic [SRC_W:0]       grant_sum;
    logic [SRC_W-1:0]     grant_idx;
    logic                 enq;
    logic                 deq;
    logic                 write_head;
    logic [ENTRY_W-1:0]   new_entry;

    // Reset and soft clear have identical effect.
    assign clear = reset | initialize;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign in_words[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate the valid vector so bit 0 corresponds to the source at rr_ptr.
    assign valid_twice   = {in_valid, in_valid} >> rr_ptr_reg;
    assign valid_rotated = valid_twice[N-1:0];

    // Lowest set bit of the rotated vector is the first valid source from rr_ptr.
    always_comb begin
        grant_found  = 1'b0;
        grant_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid_rotated[k]) begin
                grant_found  = 1'b1;
                grant_offset = SRC_W'(k);
            end
        end
    end

    assign grant_sum   = {1'b0, rr_ptr_reg} + {1'b0, grant_offset};
    assign grant_idx   = (grant_sum >= N_EXT) ? SRC_W'(grant_sum - N_EXT) : SRC_W'(grant_sum);
    assign rr_ptr_next = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;

    // Grant depends only on registered occupancy, so out_is_full never reaches in_is_taken.
    assign enq         = grant_found && (occ_reg != 2'd2) && !clear;
    assign in_is_taken = enq ? (ONE_N << grant_idx) : '0;
    assign new_entry   = {in_words[grant_idx], grant_idx};

    assign deq       = (occ_reg != 2'd0) && !out_is_full && !clear;
    assign out_valid = deq;
    assign out_data  = head_reg[ENTRY_W-1:SRC_W];
    assign out_source = head_reg[SRC_W-1:0];
    assign forwarded_count = count_reg;

    // The new entry goes to the head if the buffer is empty after this cycle's dequeue.
    assign write_head = (occ_reg == 2'd0) || ((occ_reg == 2'd1) && deq);

    // Occupancy update for enqueue/dequeue combinations.
    always_comb begin
        occ_next = occ_reg;
        case ({enq, deq})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    // Control state: occupancy, round-robin pointer and saturating transfer counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            occ_reg    <= 2'd0;
            rr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            occ_reg <= occ_next;
            if (enq) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            if (deq && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // Buffer entries; contents are don't-care whenever occupancy excludes them.
    always_ff @(posedge clk) begin
        if (deq && (occ_reg == 2'd2)) begin
            head_reg <= tail_reg;
        end
        if (enq) begin
            if (write_head) begin
                head_reg <= new_entry;
            end else begin
                tail_reg <= new_entry;
            end
        end
    end

endmodule

// File: doc/channel_arbiter.md
Name: channel_arbiter

Overview:
- N-to-1 round-robin merger for processing-unit messages.
- Sits between N upstream blocking channels (e.g. one per neighbour) and a single downstream blocking channel.
- Pops messages from the upstream channel outputs and forwards them with their source index into a 2-entry internal buffer.
- The buffer drives the downstream channel's write side at up to 1 message/clock.
- No combinational path from downstream out_is_full to any upstream in_is_taken.

Parameters:
- N, 4, number of upstream source channels (>=2).
- WIDTH, 8, message width in bits.
- SRC_W, $clog2(N), width of the source-index tag.
- CNT_W, 16, width of the forwarded-message counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- initialize  input  1  synchronous soft clear, same effect as reset.
- in_data  input  N*WIDTH  source i message at bits [i*WIDTH +: WIDTH]; first-word-fall-through.
- in_valid  input  N  source i has a message at its head.
- in_is_taken  output  N  one-hot or zero; pops source i's head this cycle.
- out_data  output  WIDTH  head message of the internal buffer.
- out_source  output  SRC_W  source index of out_data.
- out_valid  output  1  write strobe to the downstream channel.
- out_is_full  input  1  downstream channel cannot accept.
- forwarded_count  output  CNT_W  messages written downstream since the last clear; saturating.

Behaviour:
- Clear: reset or initialize (reset dominates, identical effect) clears the following, all updated synchronously:
  - buffer occupancy = 0
  - rr_ptr = 0
  - forwarded_count = 0
  - in_is_taken = 0
  - out_valid = 0
  - out_data and out_source are don't-care.
- During a clear cycle, in_is_taken = 0 and out_valid = 0.
- Buffer: 2-entry FIFO (head/tail registers plus occupancy 0..2). out_data and out_source are taken from the head.
- Downstream write:
  - out_valid = (occupancy != 0) && !out_is_full. This is the only combinational use of out_is_full.
  - A cycle with out_valid = 1 is a completed transfer; the head is dequeued and forwarded_count increments, saturating at 2^CNT_W-1.
- Grant:
  - Computed only from in_valid, registered occupancy and rr_ptr.
  - Grant allowed iff occupancy <= 1 at the start of the cycle.
  - When allowed, scan sources rr_ptr, rr_ptr+1, ... modulo N; the first i with in_valid[i] = 1 is granted.
  - On grant: in_is_taken[i] = 1 for this cycle, {in_data slice i, i} is enqueued at the edge, and rr_ptr <= (i+1) mod N.
  - No grant: in_is_taken = 0 and rr_ptr unchanged.
- Simultaneous enqueue and dequeue: occupancy is unchanged, the new entry lands behind or in place of the head correctly, and order is preserved.
- Occupancy 1 with no drain and a grant -> occupancy becomes 2.
- Occupancy 2 -> no grant. Upstream waits; its data is not popped.
- Latency: source head valid in cycle t with buffer empty -> in_is_taken in cycle t -> out_valid in cycle t+1 if !out_is_full.
- Throughput: 1 message/clock sustained while out_is_full stays low.
- Fairness: with all N sources continuously valid, grants follow 0,1,...,N-1,0,... A source waits at most N-1 grants.
- Ordering: per-source order is preserved. Messages leave in grant order.
- out_is_full held high indefinitely: buffer fills to 2, then grants stop. No message is lost or duplicated.
- in_is_taken is never asserted for a source with in_valid = 0.
- At most one in_is_taken bit is set per cycle.

Test Plan:
- Reset then idle -> out_valid = 0, in_is_taken = 0, forwarded_count = 0 for 10 cycles. Repeat with initialize pulsed mid-stream while occupancy = 2 -> next cycle out_valid = 0 and rr_ptr = 0; counter restarts from 0.
- Only source 2 valid with data 0xA5, out_is_full = 0 -> in_is_taken = 4'b0100 in cycle t; out_data = 0xA5, out_source = 2, out_valid = 1 in cycle t+1; forwarded_count = 1.
- All 4 sources continuously valid, out_is_full = 0, 12 cycles -> grant sequence 0,1,2,3 repeated 3 times; one output per cycle after 1-cycle latency; forwarded_count = 11 or 12 depending on the sampling edge; check exact.
- All sources valid, out_is_full = 1 for 5 cycles -> exactly 2 pops (sources 0,1), then in_is_taken = 0. Release full -> outputs 0,1 in order, then grants resume at source 2.
- Random in_valid and out_is_full over 10k cycles with a scoreboard per source -> no loss, no duplication, per-source order kept, waits <= N-1 grants, in_is_taken one-hot-or-zero and never set on an invalid source.
- forwarded_count with CNT_W = 4 -> after 20 transfers it reads 15 (saturated).
